multi_arbiter_game: RTL

Parametrised N-player successor to the two-player reaction game. The block runs a 4-step LED countdown and then arbitrates the first player to press. Simultaneous presses are resolved round-robin. The winner's number blinks on the LEDs, and the game re-arms once all buttons are released. It sits directly under the board top. The top maps push-buttons (active-low) to `req_in_n` and the 4 board LEDs to `leds_out`.

---
 rtl/multi_arbiter_game.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/multi_arbiter_game.sv
// N-player reaction game: a 4-step LED countdown, then a round-robin grant to the first player to press.
// Define FALSE_START_EN to disqualify players who press during the countdown.
module multi_arbiter_game #(
    parameter int unsigned NUM_PLAYERS      = 4,
    parameter int unsigned CLOCK_FREQ       = 12000000,
    parameter int unsigned PRESCALER_COUNT  = CLOCK_FREQ / 4,
    parameter int unsigned WIN_TICKS        = 8,
    parameter int unsigned GO_TIMEOUT_TICKS = 40,
    localparam int unsigned W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PLAYERS-1:0] req_in_n,
    output logic [3:0]             leds_out,
    output logic [NUM_PLAYERS-1:0] gnt_out,
    output logic [W-1:0]           winner_out,
    output logic                   winner_valid_out,
    output logic [NUM_PLAYERS-1:0] foul_out
);

    localparam int unsigned PW        = (PRESCALER_COUNT > 1) ? $clog2(PRESCALER_COUNT) : 1;
    localparam int unsigned MAX_TICKS = (GO_TIMEOUT_TICKS > WIN_TICKS) ? GO_TIMEOUT_TICKS : WIN_TICKS;
    localparam int unsigned TMAX      = (MAX_TICKS > 4) ? MAX_TICKS : 4;
    localparam int unsigned TW        = $clog2(TMAX + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALER_COUNT - 1);
    localparam logic [TW-1:0] CD_LAST    = TW'(3);
    localparam logic [TW-1:0] WIN_LAST   = TW'(WIN_TICKS - 1);
    localparam logic [TW-1:0] GO_LAST    = TW'(GO_TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CD   = 3'd1,
        GO   = 3'd2,
        WIN  = 3'd3,
        FOUL = 3'd4
    } state_t;

    state_t                 state, state_nxt;
    logic [NUM_PLAYERS-1:0] sync_q1, sync_q2, req;
    logic [PW-1:0]          presc, presc_nxt;
    logic [TW-1:0]          ticks, ticks_nxt;
    logic                   tick;
    logic [W-1:0]           ptr, ptr_nxt;
    logic [NUM_PLAYERS-1:0] foul_nxt, eligible;
    logic [W:0]             pick;
    logic [3:0]             leds_nxt;
    logic [NUM_PLAYERS-1:0] gnt_nxt;
    logic [W-1:0]           winner_nxt;
    logic                   winner_valid_nxt;
`ifdef FALSE_START_EN
    logic [NUM_PLAYERS-1:0] foul_seen;
`endif

    // First eligible player searching upward from start with wrap; MSB flags a hit.
    function automatic logic [W:0] rr_pick(input logic [NUM_PLAYERS-1:0] elig,
                                           input logic [W-1:0]           start);
        logic [W:0] res;
        int         idx;
        res = '0;
        for (int off = int'(NUM_PLAYERS) - 1; off >= 0; off--) begin
            idx = (int'(start) + off) % int'(NUM_PLAYERS);
            if (elig[W'(idx)]) res = {1'b1, W'(idx)};
        end
        return res;
    endfunction

    // Two-flop synchronizer followed by an inverting request register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
            req     <= '0;
        end else begin
            sync_q1 <= req_in_n;
            sync_q2 <= sync_q1;
            req     <= ~sync_q2;
        end
    end

    assign tick     = (presc == PRESC_LAST);
    assign eligible = req & ~foul_out;
    assign pick     = rr_pick(eligible, ptr);
`ifdef FALSE_START_EN
    assign foul_seen = foul_out | req;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        ptr_nxt          = ptr;
        gnt_nxt          = gnt_out;
        winner_nxt       = winner_out;
        winner_valid_nxt = winner_valid_out;
        foul_nxt         = foul_out;
        presc_nxt        = presc;
        ticks_nxt        = ticks;
        leds_nxt         = 4'b0000;

        case (state)
            IDLE: if (req == '0) state_nxt = CD;
            CD: begin
                if (tick && ticks == CD_LAST) state_nxt = GO;
`ifdef FALSE_START_EN
                // Everyone jumped the gun: abandon the countdown immediately.
                if (&foul_seen) state_nxt = FOUL;
`endif
            end
            GO: begin
                if (pick[W]) begin
                    state_nxt                 = WIN;
                    gnt_nxt                   = '0;
                    gnt_nxt[pick[W-1:0]]      = 1'b1;
                    winner_nxt                = pick[W-1:0];
                    winner_valid_nxt          = 1'b1;
                    ptr_nxt = (32'(pick[W-1:0]) == NUM_PLAYERS - 1) ? '0 : pick[W-1:0] + W'(1);
                end else if (tick && ticks == GO_LAST) begin
                    state_nxt = IDLE;
                end
            end
            WIN: begin
                if (tick && ticks == WIN_LAST) begin
                    state_nxt        = IDLE;
                    gnt_nxt          = '0;
                    winner_nxt       = '0;
                    winner_valid_nxt = 1'b0;
                end
            end
            FOUL: if (tick && ticks == WIN_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

`ifdef FALSE_START_EN
        if (state == CD)            foul_nxt = foul_seen;
        else if (state_nxt == CD)   foul_nxt = '0;
`else
        foul_nxt = '0;
`endif

        // Prescaler and tick count restart on every state change.
        if (state_nxt != state) begin
            presc_nxt = '0;
            ticks_nxt = '0;
        end else if (tick) begin
            presc_nxt = '0;
            ticks_nxt = ticks + TW'(1);
        end else begin
            presc_nxt = presc + PW'(1);
        end

        case (state_nxt)
            CD: begin
                if (ticks_nxt == TW'(0))      leds_nxt = 4'b1111;
                else if (ticks_nxt == TW'(1)) leds_nxt = 4'b0111;
                else if (ticks_nxt == TW'(2)) leds_nxt = 4'b0011;
                else                          leds_nxt = 4'b0001;
            end
            WIN:     leds_nxt = ticks_nxt[0] ? 4'b0000 : 4'(winner_nxt) + 4'd1;
            FOUL:    leds_nxt = ticks_nxt[0] ? 4'b0101 : 4'b1010;
            default: leds_nxt = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc            <= '0;
            ticks            <= '0;
            ptr              <= '0;
            foul_out         <= '0;
            leds_out         <= '0;
            gnt_out          <= '0;
            winner_out       <= '0;
            winner_valid_out <= 1'b0;
        end else begin
            presc            <= presc_nxt;
            ticks            <= ticks_nxt;
            ptr              <= ptr_nxt;
            foul_out         <= foul_nxt;
            leds_out         <= leds_nxt;
            gnt_out          <= gnt_nxt;
            winner_out       <= winner_nxt;
            winner_valid_out <= winner_valid_nxt;
        end
    end

endmodule
